inst_mem_ctrl: RTL and testbench

//  Sequences the single-port instruction BRAM (INST_SIZE x INST_DEPTH) between two users:
//  - a program loader (debug/UART path) writing words sequentially from address 0;
//  - the fetch stage reading by PC.

---
 rtl/inst_mem_ctrl_pkg.sv | 23 ++
 rtl/inst_mem_ctrl_fetch_resp.sv | 49 ++++
 rtl/inst_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_inst_mem_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : inst_mem_ctrl_pkg
// Brief  : Shared constants, state encodings and PC check for inst_mem_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
package inst_mem_ctrl_pkg;

   localparam int          c_INST_SIZE  = 32;
   localparam int          c_INST_DEPTH = 1024;
   localparam logic [31:0] c_NOP_INST   = 32'h0000_0013;

   localparam logic [1:0]  c_ST_HALT = 2'd0;
   localparam logic [1:0]  c_ST_LOAD = 2'd1;
   localparam logic [1:0]  c_ST_RUN  = 2'd2;

   // Word-aligned and inside the BRAM; pc[31:2] < depth is pc < 4*depth without overflow.
   function automatic logic pc_ok(input logic [31:0] pc, input int depth);
      return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < 32'(depth));
   endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mem_ctrl_fetch_resp.sv
`default_nettype none
// ============================================================================
// Module : inst_mem_ctrl_fetch_resp
// Brief  : Registered fetch response: valid/err pulses and instruction mux.
// Rev    : 1.0  initial release
// ============================================================================
module inst_mem_ctrl_fetch_resp #(
   parameter int                   INST_SIZE = 32,
   parameter logic [INST_SIZE-1:0] NOP_INST  = INST_SIZE'(32'h0000_0013)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_acc,
   input  logic                 flt_acc,
   input  logic [INST_SIZE-1:0] bram_douta,
   output logic                 fetch_valid,
   output logic                 fetch_err,
   output logic [INST_SIZE-1:0] fetch_inst
);

   logic                 r_valid;
   logic                 r_err;
   logic [INST_SIZE-1:0] r_hold;
   logic [INST_SIZE-1:0] w_inst;

   // BRAM output is already registered, so it is muxed straight through in the response cycle.
   always_comb begin
      w_inst = r_hold;
      if (r_valid) w_inst = r_err ? NOP_INST : bram_douta;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_hold  <= '0;
      end else begin
         r_valid <= rd_acc | flt_acc;
         r_err   <= flt_acc;
         r_hold  <= w_inst;
      end
   end

   assign fetch_valid = r_valid;
   assign fetch_err   = r_err;
   assign fetch_inst  = w_inst;

endmodule
`default_nettype wire

// File: rtl/inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : inst_mem_ctrl
// Brief  : Arbitrates the instruction BRAM port between program loader and fetch.
// Rev    : 1.0  initial release
// ============================================================================
module inst_mem_ctrl
   import inst_mem_ctrl_pkg::*;
#(
   parameter int                   INST_SIZE  = c_INST_SIZE,
   parameter int                   INST_DEPTH = c_INST_DEPTH,
   parameter logic [INST_SIZE-1:0] NOP_INST   = INST_SIZE'(c_NOP_INST),
   localparam int                  AW         = $clog2(INST_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic                 run_start,
   input  logic                 ld_valid,
   input  logic [INST_SIZE-1:0] ld_data,
   input  logic                 ld_last,
   output logic                 ld_ready,
   output logic [AW:0]          ld_count,
   output logic                 ld_ovf,
   input  logic                 fetch_req,
   input  logic [31:0]          fetch_pc,
   output logic                 fetch_valid,
   output logic [INST_SIZE-1:0] fetch_inst,
   output logic                 fetch_err,
   output logic                 core_stall,
   output logic                 bram_ena,
   output logic                 bram_wea,
   output logic [AW-1:0]        bram_addra,
   output logic [INST_SIZE-1:0] bram_dina,
   input  logic [INST_SIZE-1:0] bram_douta
);

   localparam logic [AW:0] c_DEPTH = (AW+1)'(INST_DEPTH);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [AW:0] r_ld_count;
   logic        r_ld_ovf;
   logic        w_in_load;
   logic        w_in_run;
   logic        w_wr;
   logic        w_rd;
   logic        w_flt;
   logic        w_pc_ok;

   assign w_in_load = (r_state == c_ST_LOAD);
   assign w_in_run  = (r_state == c_ST_RUN);
   assign w_pc_ok   = pc_ok(fetch_pc, INST_DEPTH);

   assign ld_ready  = w_in_load && (r_ld_count < c_DEPTH);
   assign w_wr      = ld_ready && ld_valid;
   // Reads only happen in RUN, so a write and a read can never share the port.
   assign w_rd      = w_in_run && fetch_req && w_pc_ok;
   assign w_flt     = w_in_run && fetch_req && !w_pc_ok;

   always_comb begin
      bram_ena   = 1'b0;
      bram_wea   = 1'b0;
      bram_addra = '0;
      bram_dina  = '0;
      if (!rst) begin
         if (w_wr) begin
            bram_ena   = 1'b1;
            bram_wea   = 1'b1;
            bram_addra = r_ld_count[AW-1:0];
            bram_dina  = ld_data;
         end else if (w_rd) begin
            bram_ena   = 1'b1;
            bram_addra = fetch_pc[AW+1:2];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_HALT: begin
            if (load_start)     w_state_nxt = c_ST_LOAD;
            else if (run_start) w_state_nxt = c_ST_RUN;
         end
         c_ST_LOAD: begin
            if (load_start)           w_state_nxt = c_ST_LOAD;
            else if (w_wr && ld_last) w_state_nxt = c_ST_RUN;
         end
         c_ST_RUN: begin
            if (load_start) w_state_nxt = c_ST_LOAD;
         end
         default: w_state_nxt = c_ST_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_ST_HALT;
         r_ld_count <= '0;
         r_ld_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (load_start)  r_ld_count <= '0;
         else if (w_wr)   r_ld_count <= r_ld_count + 1'b1;
         if (w_in_load && ld_valid && !ld_ready) r_ld_ovf <= 1'b1;
      end
   end

   assign ld_count   = r_ld_count;
   assign ld_ovf     = r_ld_ovf;
   assign core_stall = !w_in_run;

   inst_mem_ctrl_fetch_resp #(
      .INST_SIZE (INST_SIZE),
      .NOP_INST  (NOP_INST)
   ) u_fetch_resp (
      .clk         (clk),
      .rst         (rst),
      .rd_acc      (w_rd),
      .flt_acc     (w_flt),
      .bram_douta  (bram_douta),
      .fetch_valid (fetch_valid),
      .fetch_err   (fetch_err),
      .fetch_inst  (fetch_inst)
   );

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_mem_ctrl
// Brief  : Self-checking bench for inst_mem_ctrl with a behavioural BRAM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_inst_mem_ctrl;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start, run_start;
   logic          ld_valid, ld_last, ld_ready, ld_ovf;
   logic [31:0]   ld_data;
   logic [AW:0]   ld_count;
   logic          fetch_req, fetch_valid, fetch_err, core_stall;
   logic [31:0]   fetch_pc, fetch_inst;
   logic          bram_ena, bram_wea;
   logic [AW-1:0] bram_addra;
   logic [31:0]   bram_dina;
   logic [31:0]   bram_douta = 32'h0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   inst_mem_ctrl #(.INST_SIZE(32), .INST_DEPTH(DEPTH), .NOP_INST(32'h0000_0013)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .run_start(run_start),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
      .ld_count(ld_count), .ld_ovf(ld_ovf), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
      .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_err(fetch_err),
      .core_stall(core_stall), .bram_ena(bram_ena), .bram_wea(bram_wea),
      .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_douta(bram_douta)
   );

   logic [31:0] mem [DEPTH];
   always @(posedge clk) begin
      if (bram_ena) begin
         if (bram_wea) mem[bram_addra] <= bram_dina;
         else          bram_douta      <= mem[bram_addra];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct packed { logic err; logic [31:0] inst; } resp_t;
   resp_t sb[$];
   resp_t exp_r;

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_r = sb.pop_front();
         check("fetch_valid", 32'(fetch_valid), 32'd1);
         check("fetch_err",   32'(fetch_err),   32'(exp_r.err));
         check("fetch_inst",  fetch_inst,       exp_r.inst);
      end else if (fetch_valid) begin
         check("spurious_fetch_valid", 32'(fetch_valid), 32'd0);
      end
   end

   typedef struct { logic [31:0] data; logic last; } ld_vec_t;
   typedef struct { logic [31:0] pc; logic good; logic [31:0] inst; } fv_t;

   ld_vec_t ld_tab [4];
   fv_t     f_tab  [7];

   task automatic fetch_one(input logic [31:0] pc, input logic good, input logic [31:0] inst);
      fetch_req = 1'b1;
      fetch_pc  = pc;
      #1;
      check("rd_bram_ena", 32'(bram_ena), 32'(good));
      check("rd_bram_wea", 32'(bram_wea), 32'd0);
      if (good) check("rd_bram_addra", 32'(bram_addra), 32'(pc[AW+1:2]));
      sb.push_back(resp_t'{err: !good, inst: good ? inst : 32'h0000_0013});
      @(negedge clk);
   endtask

   task automatic drain();
      fetch_req = 1'b0;
      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      ld_tab[0] = '{32'h11, 1'b0};
      ld_tab[1] = '{32'h22, 1'b0};
      ld_tab[2] = '{32'h33, 1'b0};
      ld_tab[3] = '{32'h44, 1'b1};
      f_tab[0] = '{32'h0,            1'b1, 32'h11};
      f_tab[1] = '{32'h4,            1'b1, 32'h22};
      f_tab[2] = '{32'h8,            1'b1, 32'h33};
      f_tab[3] = '{32'hC,            1'b1, 32'h44};
      f_tab[4] = '{32'h6,            1'b0, 32'h0};
      f_tab[5] = '{32'(4 * DEPTH),   1'b0, 32'h0};
      f_tab[6] = '{32'h1,            1'b0, 32'h0};

      rst = 1'b1; load_start = 0; run_start = 0; ld_valid = 0; ld_data = 0;
      ld_last = 0; fetch_req = 0; fetch_pc = 0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_bram_ena",   32'(bram_ena),   32'd0);
      check("rst_bram_wea",   32'(bram_wea),   32'd0);
      check("rst_bram_addra", 32'(bram_addra), 32'd0);
      check("rst_bram_dina",  bram_dina,       32'd0);
      rst = 1'b0;
      #1;
      check("rst_ld_count",    32'(ld_count),    32'd0);
      check("rst_ld_ovf",      32'(ld_ovf),      32'd0);
      check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      check("rst_fetch_err",   32'(fetch_err),   32'd0);
      check("rst_core_stall",  32'(core_stall),  32'd1);
      check("rst_ld_ready",    32'(ld_ready),    32'd0);

      // load_start beats run_start out of HALT
      @(negedge clk);
      load_start = 1; run_start = 1;
      @(negedge clk);
      load_start = 0; run_start = 0;
      #1;
      check("prio_core_stall", 32'(core_stall), 32'd1);
      check("prio_ld_ready",   32'(ld_ready),   32'd1);

      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1; ld_data = ld_tab[i].data; ld_last = ld_tab[i].last;
         #1;
         check("ld_bram_ena",   32'(bram_ena),   32'd1);
         check("ld_bram_wea",   32'(bram_wea),   32'd1);
         check("ld_bram_addra", 32'(bram_addra), 32'(i));
         check("ld_bram_dina",  bram_dina,       ld_tab[i].data);
         @(negedge clk);
      end
      ld_valid = 0; ld_last = 0;
      #1;
      check("ld_count_4",     32'(ld_count),   32'd4);
      check("run_core_stall", 32'(core_stall), 32'd0);
      check("run_bram_idle",  32'(bram_ena),   32'd0);
      for (int i = 0; i < 4; i++) check("mem_after_load", mem[i], ld_tab[i].data);

      @(negedge clk);
      for (int i = 0; i < 7; i++) fetch_one(f_tab[i].pc, f_tab[i].good, f_tab[i].inst);
      drain();

      // read accepted in the load_start cycle still completes; nothing after it
      fetch_req = 1; fetch_pc = 32'h4; load_start = 1;
      #1;
      check("ls_bram_ena", 32'(bram_ena), 32'd1);
      sb.push_back(resp_t'{err: 1'b0, inst: 32'h22});
      @(negedge clk);
      load_start = 0; fetch_pc = 32'h8;
      #1;
      check("ls_core_stall", 32'(core_stall), 32'd1);
      check("ls_no_read",    32'(bram_ena),   32'd0);
      @(negedge clk);
      #1;
      check("ls_no_read2",   32'(bram_ena),   32'd0);
      drain();

      // fill to INST_DEPTH, then one word too many
      for (int i = 0; i < DEPTH; i++) begin
         ld_valid = 1; ld_data = 32'h100 + 32'(i); ld_last = 0;
         #1;
         check("fill_ld_ready", 32'(ld_ready), 32'd1);
         @(negedge clk);
      end
      ld_valid = 1; ld_data = 32'hDEAD; ld_last = 1;
      #1;
      check("full_ld_ready", 32'(ld_ready), 32'd0);
      check("full_bram_ena", 32'(bram_ena), 32'd0);
      @(negedge clk);
      ld_valid = 0; ld_last = 0;
      #1;
      check("ovf_flag",       32'(ld_ovf),     32'd1);
      check("ovf_ld_count",   32'(ld_count),   32'(DEPTH));
      check("ovf_core_stall", 32'(core_stall), 32'd1);
      check("ovf_mem_last",   mem[DEPTH-1],    32'h10F);

      // reset in the middle of a load
      @(negedge clk);
      load_start = 1;
      @(negedge clk);
      load_start = 0;
      #1;
      check("restart_count", 32'(ld_count), 32'd0);
      ld_valid = 1; ld_data = 32'hAA;
      @(negedge clk);
      ld_data = 32'hBB;
      @(negedge clk);
      ld_valid = 0; rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      check("mid_rst_count",  32'(ld_count),   32'd0);
      check("mid_rst_stall",  32'(core_stall), 32'd1);
      check("mid_rst_ovf",    32'(ld_ovf),     32'd0);
      check("mid_rst_ready",  32'(ld_ready),   32'd0);
      check("mid_rst_mem0",   mem[0],          32'hAA);
      check("mid_rst_mem1",   mem[1],          32'hBB);
      check("mid_rst_mem2",   mem[2],          32'h102);

      @(negedge clk);
      run_start = 1;
      @(negedge clk);
      run_start = 0;
      #1;
      check("run_start_stall", 32'(core_stall), 32'd0);
      @(negedge clk);
      fetch_one(32'h4, 1'b1, 32'hBB);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
